// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, {pc, instr} FIFO.
// Optional IFETCH_PERF_EN adds a stall_cycles counter port.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef IFETCH_PERF_EN
  output logic [31:0] stall_cycles,
`endif
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [CW:0]   used;
  logic [31:0]   new_pc;
  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;
  logic          unused;

  assign unused    = ^redirect_pc[1:0];
  assign new_pc    = {redirect_pc[31:2], 2'b00};
  assign used      = {1'b0, count} + {1'b0, outst};
  // Credit counts in-flight requests so a response always has a slot.
  assign imem_req  = !redirect && (used < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  assign resp      = imem_rvalid && (outst != '0);
  assign push      = resp && (drop == '0) && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? ins_mem[rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= resp_pc;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      resp_pc  <= {RESET_PC[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
    end else begin
      outst <= outst + CW'(accept) - CW'(resp);
      if (redirect) begin
        fetch_pc <= new_pc;
        resp_pc  <= new_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drop     <= outst - CW'(resp);
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          wr_ptr  <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (resp && (drop != '0))
          drop <= drop - CW'(1);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (instr_ready && !instr_valid && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, corner sequences and
// randomized traffic against an in-order PC stream model.
module tb_instr_fetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
`ifdef IFETCH_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .instr_ready(instr_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  req_t        mq[$];
  int          ntotal = 0;
  int          npass  = 0;
  int          cyc    = 0;
  int          lat    = 1;
  bit          rnd_gap = 0;
  bit          post_redir = 0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_pc;
  logic [31:0] stall_exp;
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_pc, o_instr;

  function automatic logic [31:0] memfn(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mq.delete();
    exp_fetch  = 32'h0;
    exp_pc     = 32'h0;
    stall_exp  = 32'h0;
    post_redir = 0;
    lat        = 1;
    rnd_gap    = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at the negedge, observe 1 time unit later.
  task automatic cycle(input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic mrdy);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ready  = mrdy;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc &&
        (!rnd_gap || $urandom_range(0, 3) != 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_valid = instr_valid;
    o_pc    = instr_pc;
    o_instr = instr;
    if (redir) chk("req_in_redirect", {31'b0, o_req}, 32'd0);
    if (post_redir) chk("empty_after_redirect", {31'b0, o_valid}, 32'd0);
    if (!o_valid) begin
      chk("nop_instr", o_instr, NOP);
      chk("nop_pc", o_pc, 32'h0);
    end
    if (o_req) chk("imem_addr", o_addr, exp_fetch);
`ifdef IFETCH_PERF_EN
    chk("stall_cycles", stall_cycles, stall_exp);
    if (rdy && !o_valid && stall_exp != 32'hFFFF_FFFF) stall_exp++;
`endif
    if (o_req && mrdy) begin
      mq.push_back('{addr: o_addr, due: cyc + lat});
      exp_fetch += 32'd4;
    end
    if (o_valid && rdy && !redir) begin
      chk("instr_pc", o_pc, exp_pc);
      chk("instr_data", o_instr, memfn(exp_pc));
      exp_pc += 32'd4;
    end
    if (redir) begin
      exp_fetch = {rpc[31:2], 2'b00};
      exp_pc    = {rpc[31:2], 2'b00};
    end
    if (mq.size() > DEPTH) chk("outstanding_bound", mq.size(), DEPTH);
    post_redir = redir;
    cyc++;
    @(negedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    int  n;
    logic [31:0] r;

    vecs[0] = '{1, 0, 32'h0,   1, 32'h000, 0, 32'h000};
    vecs[1] = '{1, 0, 32'h0,   1, 32'h004, 0, 32'h000};
    vecs[2] = '{1, 0, 32'h0,   1, 32'h008, 1, 32'h000};
    vecs[3] = '{1, 0, 32'h0,   1, 32'h00C, 1, 32'h004};
    vecs[4] = '{1, 0, 32'h0,   1, 32'h010, 1, 32'h008};
    vecs[5] = '{1, 1, 32'h203, 0, 32'h014, 1, 32'h00C};
    vecs[6] = '{1, 0, 32'h0,   1, 32'h200, 0, 32'h000};
    vecs[7] = '{1, 0, 32'h0,   1, 32'h204, 0, 32'h000};
    vecs[8] = '{1, 0, 32'h0,   1, 32'h208, 1, 32'h200};
    vecs[9] = '{1, 0, 32'h0,   1, 32'h20C, 1, 32'h204};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].rdy, vecs[i].redir, vecs[i].rpc, 1'b1);
      chk($sformatf("vec%0d_req", i), {31'b0, o_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("vec%0d_addr", i), o_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_instr", i), o_instr,
          vecs[i].exp_valid ? memfn(vecs[i].exp_pc) : NOP);
    end

    // Backpressure: FIFO fills, requests stop, stream resumes intact.
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("full_req_low", {31'b0, o_req}, 32'd0);
    chk("full_valid", {31'b0, o_valid}, 32'd1);
    repeat (12) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Latency 3: redirect with two requests in flight.
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    lat = 3;
    n = 0;
    while (mq.size() > 0 && n < 20) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("drain_done", mq.size(), 0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("two_outstanding", mq.size(), 2);
    cycle(1'b1, 1'b1, 32'h100, 1'b1);
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      n++;
    end while (!o_valid && n < 20);
    chk("first_after_redirect_valid", {31'b0, o_valid}, 32'd1);
    chk("first_after_redirect_pc", o_pc, 32'h100);
    repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect together with a response and a pop.
    lat = 1;
    cycle(1'b1, 1'b1, 32'h80, 1'b1);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h300, 1'b1);
    chk("coincident_head_valid", {31'b0, o_valid}, 32'd1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("coincident_empty", {31'b0, o_valid}, 32'd0);
    chk("coincident_nop", o_instr, NOP);
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Address wrap at the top of the address space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr_top", o_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr_zero", o_addr, 32'h0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    rnd_gap = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0 && mq.size() == 0) lat = $urandom_range(1, 3);
      r = $urandom;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, r,
            $urandom_range(0, 4) != 0);
    end

    // Mid-stream reset; stall counter from a clean start.
    do_reset();
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
`ifdef IFETCH_PERF_EN
    chk("stall_five", stall_cycles, 32'd5);
`endif
    chk("reset_empty", {31'b0, o_valid}, 32'd0);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stream_after_reset", {31'b0, o_valid}, 32'd1);
`ifdef IFETCH_PERF_EN
    chk("stall_holds", stall_cycles, 32'd5);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
